cpu_mem_responder: RTL

//  Memory-side responder for the 8-bit multicycle CPU data/instruction port (memEnable/memAdr/memWD/memRD).

---
 rtl/cpu_mem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
//
// Memory-side responder for an 8-bit multicycle CPU. A single unified RAM
// serves both instruction fetches and data accesses. The program is first
// streamed in over a valid/ready byte interface, with the CPU held in reset.
// The CPU is then released. The first CPU store to RESULT_ADR is captured as
// the program result, and after that store the RAM is frozen against the CPU.
//
// Ports
//   clk           system clock, all state changes on posedge
//   reset         synchronous, active-high
//   load_valid    loader byte valid
//   load_ready    responder accepts loader byte (high in LOAD)
//   load_data     program byte
//   load_last     marks final program byte
//   cpu_reset     CPU reset, high while loading
//   memEnable     CPU write enable
//   memAdr        CPU address
//   memWD         CPU write data
//   memRD         read data to CPU (combinational, zero latency)
//   result        captured result byte
//   result_valid  result captured, CPU program finished
//   write_count   CPU writes accepted in RUN, saturating
// ---------------------------------------------------------------------------
module cpu_mem_responder #(
    parameter int              WIDTH      = 8,
    parameter int              DEPTH      = 256,
    parameter logic [WIDTH-1:0] RESULT_ADR = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             cpu_reset,
    input  logic             memEnable,
    input  logic [WIDTH-1:0] memAdr,
    input  logic [WIDTH-1:0] memWD,
    output logic [WIDTH-1:0] memRD,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] write_count
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // RAM has no reset: its contents survive a reset on purpose.
    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_reg;
    logic [WIDTH-1:0] ptr_reg;
    logic [WIDTH-1:0] result_reg;
    logic             result_valid_reg;
    logic [WIDTH-1:0] write_count_reg;

    logic             addr_ok;
    logic             ptr_last;
    logic             wr_en;
    logic [WIDTH-1:0] wr_adr;
    logic [WIDTH-1:0] wr_data;

    // Addresses at or beyond DEPTH are not backed by RAM.
    assign addr_ok  = (32'(memAdr) < 32'(DEPTH));
    assign ptr_last = (32'(ptr_reg) == 32'(DEPTH - 1));

    // Single RAM write port shared by the loader and the CPU; the state
    // decides who owns it, so a CPU write during LOAD can never collide.
    always_comb begin
        wr_en   = 1'b0;
        wr_adr  = memAdr;
        wr_data = memWD;
        if (!reset) begin
            case (state_reg)
                LOAD: begin
                    if (load_valid) begin
                        wr_en   = 1'b1;
                        wr_adr  = ptr_reg;
                        wr_data = load_data;
                    end
                end
                RUN: begin
                    if (memEnable && addr_ok) begin
                        wr_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    // Asynchronous read: the CPU samples memRD in the same cycle it drives
    // memAdr. A same-address write shows up only after the edge.
    assign memRD = addr_ok ? mem[memAdr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= LOAD;
            ptr_reg          <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            write_count_reg  <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (load_valid) begin
                        // Leave the pointer parked on the last word rather
                        // than wrapping it back onto byte 0.
                        if (load_last || ptr_last) begin
                            state_reg <= RUN;
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (memEnable) begin
                        if (write_count_reg != '1) begin
                            write_count_reg <= write_count_reg + 1'b1;
                        end
                        if (memAdr == RESULT_ADR) begin
                            result_reg       <= memWD;
                            result_valid_reg <= 1'b1;
                            state_reg        <= HALT;
                        end
                    end
                end
                HALT: ;
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign load_ready   = (state_reg == LOAD);
    assign cpu_reset    = (state_reg == LOAD);
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign write_count  = write_count_reg;

endmodule
